// File: rtl/chunked_adder_seq_pkg.sv
// ----------------------------------------------------------------------------
// chunked_adder_seq_pkg
// Items shared by the chunked adder/subtractor:
//   state_t   - controller state encoding (ST_IDLE / ST_RUN)
//   MODE_ADD  - mode value selecting a + b + c_in
//   MODE_SUB  - mode value selecting a - b - c_in
//   clog2()   - ceiling log2, used to size the chunk counter
// ----------------------------------------------------------------------------
package chunked_adder_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/chunked_adder_seq_chunk_adder.sv
// ----------------------------------------------------------------------------
// chunk_adder
// Combinational CHUNK-bit ripple-carry adder slice.
// Ports:
//   x, y  [CHUNK-1:0]  addends
//   ci                 carry in
//   s     [CHUNK-1:0]  sum
//   co                 carry out of the slice MSB
//   cmsb               carry into the slice MSB (xor with co gives signed overflow)
// ----------------------------------------------------------------------------
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             cmsb
);

    always_comb begin : ripple
        logic c;
        c    = ci;
        s    = '0;
        cmsb = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            // Capture the carry that feeds the top bit before it is updated.
            if (i == CHUNK - 1) begin
                cmsb = c;
            end
            c = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        co = c;
    end

endmodule

// File: rtl/chunked_adder_seq.sv
// ----------------------------------------------------------------------------
// chunked_adder_seq
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock,
// with the inter-chunk carry held in a register.
// Ports:
//   clk    clock, rising edge
//   reset  synchronous active-high reset
//   start  request, taken only while ready=1
//   ready  idle, able to accept start
//   mode   0 = a + b + c_in, 1 = a - b - c_in
//   a, b   [WIDTH-1:0] operands, sampled at acceptance
//   c_in   carry-in (add) / borrow-in (subtract), sampled at acceptance
//   sum    [WIDTH-1:0] result, held until the next completion
//   c_out  carry out of the MSB (for subtract, 1 = no borrow)
//   ovf    signed two's-complement overflow
//   done   one-cycle pulse marking updated sum/c_out/ovf
// ----------------------------------------------------------------------------
module chunked_adder_seq
    import chunked_adder_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             done
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);

    state_t             state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_next;
    logic               carry;
    logic [CW-1:0]      count;
    logic [31:0]        base;
    logic               last;

    logic [CHUNK-1:0]   x_chunk;
    logic [CHUNK-1:0]   y_chunk;
    logic [CHUNK-1:0]   s_chunk;
    logic               co_chunk;
    logic               cmsb_chunk;

    assign base = 32'(count) * 32'(CHUNK);
    assign last = (count == CW'(NCHUNK - 1));

    // Select the operand slices for the current chunk and merge its sum into
    // a copy of the accumulator, so the final edge can publish the complete
    // result directly without an extra cycle.
    always_comb begin
        x_chunk  = op_a[base +: CHUNK];
        y_chunk  = op_b[base +: CHUNK];
        acc_next = acc;
        acc_next[base +: CHUNK] = s_chunk;
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .x    (x_chunk),
        .y    (y_chunk),
        .ci   (carry),
        .s    (s_chunk),
        .co   (co_chunk),
        .cmsb (cmsb_chunk)
    );

    // Controller. Subtraction is a + ~b + ~c_in, so the operand and carry are
    // inverted once at acceptance and the datapath only ever adds. Outputs
    // are written only on the last chunk, keeping partial results hidden.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            count <= '0;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= (mode == MODE_SUB) ? ~b : b;
                        carry <= (mode == MODE_SUB) ? ~c_in : c_in;
                        count <= '0;
                        acc   <= '0;
                        ready <= 1'b0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_next;
                    carry <= co_chunk;
                    if (last) begin
                        sum   <= acc_next;
                        c_out <= co_chunk;
                        ovf   <= co_chunk ^ cmsb_chunk;
                        done  <= 1'b1;
                        ready <= 1'b1;
                        count <= '0;
                        state <= ST_IDLE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
